countdown_timer: RTL and testbench

//  Cooking-time source for the microwave controller; sits directly upstream of the magnetron control stage.

---
 rtl/countdown_timer_if.sv | 23 ++
 rtl/countdown_timer.sv | 83 ++++++++
 tb/tb_countdown_timer.sv | 180 ++++++++++++++++++
 3 files changed

// File: rtl/countdown_timer_if.sv
// rtl/countdown_timer_if.sv - keypad/magnetron inputs and BCD time outputs of the countdown timer
interface countdown_timer_if;
    logic       clearn;
    logic       key_valid;
    logic [3:0] key_digit;
    logic       mag_on;
    logic [3:0] sec_ones;
    logic [3:0] sec_tens;
    logic [3:0] min_ones;
    logic [3:0] min_tens;
    logic       timer_done;
    logic       done_pulse;

    modport master (
        output clearn, key_valid, key_digit, mag_on,
        input  sec_ones, sec_tens, min_ones, min_tens, timer_done, done_pulse
    );

    modport slave (
        input  clearn, key_valid, key_digit, mag_on,
        output sec_ones, sec_tens, min_ones, min_tens, timer_done, done_pulse
    );
endinterface

// File: rtl/countdown_timer.sv
// rtl/countdown_timer.sv - keypad-loaded MM:SS BCD countdown with one-second prescaler
module countdown_timer #(
    parameter int TICKS_PER_SEC = 100
) (
    input logic             clk,
    input logic             rst,
    countdown_timer_if.slave tif
);
    localparam int PW = $clog2(TICKS_PER_SEC);
    localparam logic [PW-1:0] PS_LAST = PW'(TICKS_PER_SEC - 1);

    logic [3:0]    sec_ones, sec_tens, min_ones, min_tens;
    logic [3:0]    dec_so, dec_st, dec_mo, dec_mt;
    logic [PW-1:0] prescaler;
    logic          done_pulse;
    logic          timer_done;
    logic          counting;
    logic          tick;
    logic          key_ok;

    assign timer_done = ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0000);
    // Counting stops at zero, which also freezes the prescaler.
    assign counting   = tif.mag_on && !timer_done;
    assign tick       = counting && (prescaler == PS_LAST);
    assign key_ok     = tif.key_valid && !tif.mag_on && (tif.key_digit <= 4'd9);

    always_comb begin
        dec_so = sec_ones;
        dec_st = sec_tens;
        dec_mo = min_ones;
        dec_mt = min_tens;
        if (sec_ones != 4'd0) begin
            dec_so = sec_ones - 4'd1;
        end else if (sec_tens != 4'd0) begin
            dec_so = 4'd9;
            dec_st = sec_tens - 4'd1;
        end else begin
            // Seconds wrap to 59 even when typed as e.g. "90"; minutes then borrow.
            dec_so = 4'd9;
            dec_st = 4'd5;
            if (min_ones != 4'd0) begin
                dec_mo = min_ones - 4'd1;
            end else begin
                dec_mo = 4'd9;
                dec_mt = min_tens - 4'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst || !tif.clearn) begin
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min_ones   <= 4'd0;
            min_tens   <= 4'd0;
            prescaler  <= '0;
            done_pulse <= 1'b0;
        end else begin
            done_pulse <= tick && ({min_tens, min_ones, sec_tens, sec_ones} == 16'h0001);
            if (counting) begin
                prescaler <= tick ? '0 : prescaler + PW'(1);
            end
            if (tick) begin
                sec_ones <= dec_so;
                sec_tens <= dec_st;
                min_ones <= dec_mo;
                min_tens <= dec_mt;
            end else if (key_ok) begin
                min_tens <= min_ones;
                min_ones <= sec_tens;
                sec_tens <= sec_ones;
                sec_ones <= tif.key_digit;
            end
        end
    end

    assign tif.sec_ones   = sec_ones;
    assign tif.sec_tens   = sec_tens;
    assign tif.min_ones   = min_ones;
    assign tif.min_tens   = min_tens;
    assign tif.timer_done = timer_done;
    assign tif.done_pulse = done_pulse;
endmodule

// File: tb/tb_countdown_timer.sv
// tb/tb_countdown_timer.sv - directed bench for countdown_timer with TICKS_PER_SEC=4
module tb_countdown_timer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   total = 0;
    int   bad = 0;

    countdown_timer_if tif ();

    countdown_timer #(.TICKS_PER_SEC(4)) dut (
        .clk (clk),
        .rst (rst),
        .tif (tif.slave)
    );

    always #5 clk = ~clk;

    logic [15:0] count;
    assign count = {tif.min_tens, tif.min_ones, tif.sec_tens, tif.sec_ones};

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic key(input logic [3:0] d);
        tif.key_valid = 1'b1;
        tif.key_digit = d;
        cyc(1);
        tif.key_valid = 1'b0;
        tif.key_digit = 4'd0;
    endtask

    task automatic clear();
        tif.clearn = 1'b0;
        cyc(1);
        tif.clearn = 1'b1;
    endtask

    initial begin
        tif.clearn    = 1'b1;
        tif.key_valid = 1'b0;
        tif.key_digit = 4'd0;
        tif.mag_on    = 1'b0;
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        chk("reset_count", count, 16'h0000);
        chk("reset_done", {15'd0, tif.timer_done}, 16'd1);
        chk("reset_pulse", {15'd0, tif.done_pulse}, 16'd0);
        tif.mag_on = 1'b1;
        cyc(20);
        chk("zero_saturate", count, 16'h0000);
        chk("zero_no_pulse", {15'd0, tif.done_pulse}, 16'd0);
        tif.mag_on = 1'b0;

        key(4'd1); key(4'd3); key(4'd0);
        chk("entry_0130", count, 16'h0130);
        chk("entry_not_done", {15'd0, tif.timer_done}, 16'd0);
        key(4'd11);
        chk("key_gt9_ignored", count, 16'h0130);
        tif.mag_on = 1'b1;
        key(4'd7);
        tif.mag_on = 1'b0;
        chk("key_mag_on_ignored", count, 16'h0130);

        clear();
        key(4'd1); key(4'd3); key(4'd0);
        tif.mag_on = 1'b1;
        cyc(3);
        chk("before_first_tick", count, 16'h0130);
        cyc(1);
        chk("first_tick", count, 16'h0129);
        cyc(4);
        chk("second_tick", count, 16'h0128);
        cyc(4 * 28);
        chk("reach_0100", count, 16'h0100);
        cyc(4);
        chk("borrow_0059", count, 16'h0059);
        tif.mag_on = 1'b0;

        clear();
        key(4'd2);
        tif.mag_on = 1'b1;
        cyc(4);
        chk("run_0001", count, 16'h0001);
        cyc(3);
        chk("hold_0001", count, 16'h0001);
        chk("no_early_pulse", {15'd0, tif.done_pulse}, 16'd0);
        cyc(1);
        chk("reach_0000", count, 16'h0000);
        chk("done_pulse_high", {15'd0, tif.done_pulse}, 16'd1);
        chk("timer_done_high", {15'd0, tif.timer_done}, 16'd1);
        cyc(1);
        chk("done_pulse_one_cycle", {15'd0, tif.done_pulse}, 16'd0);
        cyc(10);
        chk("stay_0000", count, 16'h0000);
        tif.mag_on = 1'b0;

        key(4'd5);
        tif.mag_on = 1'b1;
        cyc(2);
        tif.mag_on = 1'b0;
        cyc(10);
        chk("pause_hold", count, 16'h0005);
        tif.mag_on = 1'b1;
        cyc(1);
        chk("resume_no_tick", count, 16'h0005);
        cyc(1);
        chk("resume_tick", count, 16'h0004);

        cyc(3);
        tif.clearn    = 1'b0;
        tif.key_valid = 1'b1;
        tif.key_digit = 4'd7;
        cyc(1);
        tif.clearn    = 1'b1;
        tif.key_valid = 1'b0;
        chk("clear_priority", count, 16'h0000);
        chk("clear_no_pulse", {15'd0, tif.done_pulse}, 16'd0);
        chk("clear_done", {15'd0, tif.timer_done}, 16'd1);
        tif.mag_on = 1'b0;
        key(4'd3);
        tif.mag_on = 1'b1;
        cyc(3);
        chk("clear_ps_zero_a", count, 16'h0003);
        cyc(1);
        chk("clear_ps_zero_b", count, 16'h0002);

        cyc(3);
        rst = 1'b1;
        tif.key_valid = 1'b1;
        tif.key_digit = 4'd4;
        cyc(1);
        rst = 1'b0;
        tif.key_valid = 1'b0;
        chk("rst_mid_run", count, 16'h0000);
        chk("rst_no_pulse", {15'd0, tif.done_pulse}, 16'd0);
        tif.mag_on = 1'b0;
        key(4'd2);
        tif.mag_on = 1'b1;
        cyc(3);
        chk("rst_ps_zero_a", count, 16'h0002);
        cyc(1);
        chk("rst_ps_zero_b", count, 16'h0001);
        tif.mag_on = 1'b0;

        clear();
        key(4'd9); key(4'd9); key(4'd9); key(4'd9);
        chk("entry_9999", count, 16'h9999);
        tif.mag_on = 1'b1;
        cyc(4);
        chk("max_9998", count, 16'h9998);
        cyc(4 * 39);
        chk("max_9959", count, 16'h9959);
        cyc(4);
        chk("max_9958", count, 16'h9958);
        cyc(4 * 59);
        chk("min_borrow_9859", count, 16'h9859);
        tif.mag_on = 1'b0;

        clear();
        key(4'd1); key(4'd0); key(4'd0); key(4'd0);
        tif.mag_on = 1'b1;
        cyc(4);
        chk("tens_borrow_0959", count, 16'h0959);
        tif.mag_on = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
